fm_layer_seq: RTL and testbench

FM_LAYER_SEQ -- requirements
Module: fm_layer_seq

---
 rtl/diff_core_pkg.sv | 19 +
 rtl/fm_desc_fifo.sv | 46 ++++
 rtl/fm_layer_seq.sv | 164 ++++++++++++++++
 tb/tb_fm_layer_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_core_pkg.sv
// Shared types for the feature-map layer sequencer: the layer descriptor and the sequencer FSM states.
package diff_core_pkg;

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] h;
        logic [7:0] c;
        logic       kernal_mode;
        logic       bit_mode;
    } layer_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fm_desc_fifo.sv
// Synchronous descriptor FIFO; a push is still taken while full if a pop happens in the same cycle.
module fm_desc_fifo
    import diff_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  layer_desc_t din,
    output layer_desc_t dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    layer_desc_t     mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fm_layer_seq.sv
// Layer sequencer: queues layer descriptors, hands each to the guard controller and paces its psum beats.
// Optional DRAIN watchdog enabled by defining FM_SEQ_WDOG_EN.
module fm_layer_seq
    import diff_core_pkg::*;
#(
    parameter int DESC_DEPTH  = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       desc_valid,
    output logic       desc_ready,
    input  logic [7:0] desc_w,
    input  logic [7:0] desc_h,
    input  logic [7:0] desc_c,
    input  logic       desc_kernal_mode,
    input  logic       desc_bit_mode,
    output logic       ctrl_valid,
    input  logic       ctrl_ready,
    input  logic       ctrl_finish,
    output logic [7:0] w_num_o,
    output logic [7:0] h_num_o,
    output logic [7:0] c_num_o,
    output logic       kernal_mode_o,
    output logic       bit_mode_o,
    input  logic       psum_src_valid,
    output logic       psum_almost_valid,
    output logic       busy,
    output logic       layer_done,
    output logic [7:0] layer_cnt,
    output logic       err_wdog
);

    if (DESC_DEPTH < 2 || (DESC_DEPTH & (DESC_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DESC_DEPTH must be a power of two and at least 2");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 1");
    end

    layer_desc_t desc_in;
    layer_desc_t head;
    layer_desc_t cfg_q;
    layer_desc_t cfg_out;
    seq_state_t  state_q;
    seq_state_t  state_d;
    logic [7:0]  bw_q;
    logic [7:0]  bh_q;
    logic [7:0]  bc_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        strobe;
    logic        last_beat;
    logic        finish_hit;
    logic        wdog_hit;

    assign desc_in = '{w: desc_w, h: desc_h, c: desc_c,
                       kernal_mode: desc_kernal_mode, bit_mode: desc_bit_mode};

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign pop        = ctrl_valid && ctrl_ready;
    assign desc_ready = !fifo_full || pop;
    assign push       = desc_valid && desc_ready;

    fm_desc_fifo #(
        .DEPTH (DESC_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (desc_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign ctrl_valid        = (state_q == ST_ISSUE);
    assign strobe            = (state_q == ST_RUN) && psum_src_valid;
    assign psum_almost_valid = strobe;
    assign last_beat         = strobe && (bw_q == 8'd0) && (bh_q == 8'd0) && (bc_q == 8'd0);
    assign finish_hit        = (state_q == ST_DRAIN) && ctrl_finish;
    assign layer_done        = finish_hit;
    assign busy              = (state_q != ST_IDLE) || !fifo_empty;

    assign cfg_out       = ctrl_valid ? head : cfg_q;
    assign w_num_o       = cfg_out.w;
    assign h_num_o       = cfg_out.h;
    assign c_num_o       = cfg_out.c;
    assign kernal_mode_o = cfg_out.kernal_mode;
    assign bit_mode_o    = cfg_out.bit_mode;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: if (ctrl_ready)  state_d = ST_RUN;
            ST_RUN:   if (last_beat)   state_d = ST_DRAIN;
            ST_DRAIN: if (finish_hit || wdog_hit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            bw_q      <= 8'd0;
            bh_q      <= 8'd0;
            bc_q      <= 8'd0;
            layer_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                cfg_q <= head;
                bw_q  <= head.w;
                bh_q  <= head.h;
                bc_q  <= head.c;
            end else if (strobe) begin
                // Width is the innermost dimension, channel the outermost.
                if (bw_q != 8'd0) begin
                    bw_q <= bw_q - 8'd1;
                end else if (bh_q != 8'd0) begin
                    bw_q <= cfg_q.w;
                    bh_q <= bh_q - 8'd1;
                end else if (bc_q != 8'd0) begin
                    bw_q <= cfg_q.w;
                    bh_q <= cfg_q.h;
                    bc_q <= bc_q - 8'd1;
                end
            end
            if (finish_hit) layer_cnt <= layer_cnt + 8'd1;
        end
    end

`ifdef FM_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              err_q;

    assign wdog_hit = (state_q == ST_DRAIN) && !ctrl_finish &&
                      (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
    assign err_wdog = err_q;

    // Held at zero outside DRAIN so every DRAIN visit starts a fresh count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q != ST_DRAIN) wdog_cnt <= '0;
            else if (!wdog_hit)      wdog_cnt <= wdog_cnt + WDOG_W'(1);
            if (wdog_hit) err_q <= 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
    assign err_wdog = 1'b0;
`endif

endmodule

// File: tb/tb_fm_layer_seq.sv
// Self-checking bench for fm_layer_seq: descriptor table plus hand-written backpressure, reset and DRAIN sequences.
module tb_fm_layer_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       desc_valid = 1'b0;
    logic       desc_ready;
    logic [7:0] desc_w = '0;
    logic [7:0] desc_h = '0;
    logic [7:0] desc_c = '0;
    logic       desc_kernal_mode = 1'b0;
    logic       desc_bit_mode = 1'b0;
    logic       ctrl_valid;
    logic       ctrl_ready = 1'b0;
    logic       ctrl_finish = 1'b0;
    logic [7:0] w_num_o;
    logic [7:0] h_num_o;
    logic [7:0] c_num_o;
    logic       kernal_mode_o;
    logic       bit_mode_o;
    logic       psum_src_valid = 1'b0;
    logic       psum_almost_valid;
    logic       busy;
    logic       layer_done;
    logic [7:0] layer_cnt;
    logic       err_wdog;

    fm_layer_seq #(
        .DESC_DEPTH  (4),
        .WDOG_CYCLES (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .desc_valid        (desc_valid),
        .desc_ready        (desc_ready),
        .desc_w            (desc_w),
        .desc_h            (desc_h),
        .desc_c            (desc_c),
        .desc_kernal_mode  (desc_kernal_mode),
        .desc_bit_mode     (desc_bit_mode),
        .ctrl_valid        (ctrl_valid),
        .ctrl_ready        (ctrl_ready),
        .ctrl_finish       (ctrl_finish),
        .w_num_o           (w_num_o),
        .h_num_o           (h_num_o),
        .c_num_o           (c_num_o),
        .kernal_mode_o     (kernal_mode_o),
        .bit_mode_o        (bit_mode_o),
        .psum_src_valid    (psum_src_valid),
        .psum_almost_valid (psum_almost_valid),
        .busy              (busy),
        .layer_done        (layer_done),
        .layer_cnt         (layer_cnt),
        .err_wdog          (err_wdog)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] w;
        logic [7:0] h;
        logic [7:0] c;
        logic       km;
        logic       bm;
        int         beats;
        bit         rnd;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[6];
    vec_t bp[5];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   pop_cyc = 0;
    int   done_cyc = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one descriptor and waits (bounded) for acceptance; acc is the accepting cycle.
    task automatic push_desc(input vec_t v, output int acc);
        int t = 0;
        desc_w = v.w; desc_h = v.h; desc_c = v.c;
        desc_kernal_mode = v.km; desc_bit_mode = v.bm;
        desc_valid = 1'b1;
        #4;
        while (!desc_ready && t < 200) begin
            step();
            #4;
            t++;
        end
        chk("push_accept", desc_ready, 1);
        acc = cyc;
        sb.push_back(v);
        step();
        desc_valid = 1'b0;
    endtask

    // Plays the guard controller for one layer.
    task automatic guard_layer(input int exp_gap, input int drain_wait, input bit withhold);
        int   t = 0;
        int   n = 0;
        int   stray = 0;
        vec_t e;
        psum_src_valid = 1'b1;
        while (!ctrl_valid && t < 200) begin
            #4;
            if (psum_almost_valid) stray++;
            step();
            t++;
        end
        chk("issue_seen", ctrl_valid, 1);
        if (!ctrl_valid) return;
        if (exp_gap >= 0) chk("issue_gap", cyc - done_cyc, exp_gap);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("cfg_issue", {w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o},
            {e.w, e.h, e.c, e.km, e.bm});
        ctrl_ready = 1'b1;
        pop_cyc = cyc;
        #4;
        if (psum_almost_valid) stray++;
        step();
        ctrl_ready = 1'b0;
        chk("ctrl_valid_after_pop", ctrl_valid, 0);
        t = 0;
        while (n < e.beats && t < 4000) begin
            psum_src_valid = e.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (psum_almost_valid) n++;
            step();
            t++;
        end
        psum_src_valid = 1'b1;
        repeat (3) begin
            #4;
            if (psum_almost_valid) stray++;
            step();
        end
        chk("beats", n, e.beats);
        chk("stray_strobes", stray, 0);
        chk("cfg_hold", {w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o},
            {e.w, e.h, e.c, e.km, e.bm});
        psum_src_valid = 1'b0;
        if (withhold) begin
            repeat (12) step();
            chk("wdog_not_yet", err_wdog, 0);
            chk("wdog_still_drain", busy, 1);
            step();
            chk("wdog_err", err_wdog, 1);
            chk("wdog_idle", busy, 0);
            chk("wdog_layer_cnt", layer_cnt, exp_cnt);
            return;
        end
        repeat (drain_wait) step();
        if (drain_wait > 0) begin
            chk("drain_no_err", err_wdog, 0);
            chk("drain_waiting", busy, 1);
        end
        ctrl_finish = 1'b1;
        #4;
        chk("layer_done", layer_done, 1);
        done_cyc = cyc;
        step();
        ctrl_finish = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        chk("layer_cnt", layer_cnt, exp_cnt);
        chk("layer_done_pulse", layer_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int acc;
        int acc5;

        tbl[0] = '{8'd1, 8'd1, 8'd0, 1'b0, 1'b1, 4,  1'b0};
        tbl[1] = '{8'd2, 8'd0, 8'd1, 1'b1, 1'b0, 6,  1'b1};
        tbl[2] = '{8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1,  1'b0};
        tbl[3] = '{8'd3, 8'd2, 8'd1, 1'b0, 1'b0, 24, 1'b1};
        tbl[4] = '{8'd0, 8'd4, 8'd0, 1'b1, 1'b0, 5,  1'b1};
        tbl[5] = '{8'd2, 8'd2, 8'd2, 1'b1, 1'b1, 27, 1'b0};
        for (int i = 0; i < 5; i++)
            bp[i] = '{8'(i), 8'(4 - i), 8'(i % 2), 1'(i), 1'(i + 1), (i + 1) * (5 - i) * (i % 2 + 1), 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_ctrl_valid", ctrl_valid, 0);
        chk("rst_cfg", {w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_layer_cnt", layer_cnt, 0);
        chk("rst_err", err_wdog, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            push_desc(tbl[i], acc);
            guard_layer(-1, 0, 1'b0);
        end

        // finish while idle must be ignored
        ctrl_finish = 1'b1;
        #4;
        chk("finish_idle_no_done", layer_done, 0);
        step();
        ctrl_finish = 1'b0;
        chk("finish_idle_cnt", layer_cnt, exp_cnt);

        // backpressure: queue fills, fifth push lands in the first pop cycle
        ctrl_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_desc(bp[i], acc);
        #4;
        chk("full_desc_ready", desc_ready, 0);
        chk("full_busy", busy, 1);
        step();
        fork
            push_desc(bp[4], acc5);
            guard_layer(-1, 0, 1'b0);
        join
        chk("push_in_pop_cycle", acc5, pop_cyc);
        for (int i = 1; i < 5; i++) guard_layer(2, 0, 1'b0);
        chk("bp_layer_cnt", layer_cnt, 11);

`ifdef FM_SEQ_WDOG_EN
        push_desc('{8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 2, 1'b0}, acc);
        guard_layer(-1, 0, 1'b1);
        push_desc('{8'd0, 8'd1, 8'd0, 1'b1, 1'b0, 2, 1'b0}, acc);
        guard_layer(-1, 0, 1'b0);
        chk("wdog_sticky", err_wdog, 1);
`else
        push_desc('{8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 2, 1'b0}, acc);
        guard_layer(-1, 40, 1'b0);
`endif

        // reset in the middle of RUN with one descriptor still queued
        push_desc('{8'd7, 8'd7, 8'd7, 1'b1, 1'b1, 512, 1'b0}, acc);
        push_desc('{8'd5, 8'd5, 8'd5, 1'b1, 1'b1, 216, 1'b0}, acc);
        chk("pre_rst_issue", ctrl_valid, 1);
        ctrl_ready = 1'b1;
        step();
        ctrl_ready = 1'b0;
        psum_src_valid = 1'b1;
        repeat (5) step();
        chk("pre_rst_strobe", psum_almost_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_desc_ready", desc_ready, 1);
        chk("mid_rst_ctrl_valid", ctrl_valid, 0);
        chk("mid_rst_strobe", psum_almost_valid, 0);
        chk("mid_rst_cfg", {w_num_o, h_num_o, c_num_o, kernal_mode_o, bit_mode_o}, 0);
        chk("mid_rst_done", layer_done, 0);
        chk("mid_rst_cnt", layer_cnt, 0);
        chk("mid_rst_err", err_wdog, 0);
        chk("mid_rst_busy", busy, 0);
        sb.delete();
        exp_cnt = 0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_queue_empty", busy, 0);
        chk("post_rst_no_issue", ctrl_valid, 0);
        chk("post_rst_no_strobe", psum_almost_valid, 0);
        psum_src_valid = 1'b0;

        push_desc(tbl[0], acc);
        guard_layer(-1, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
